rp_decoupler: RTL and testbench

RP_DECOUPLER -- requirements
Module: rp_decoupler

---
 rtl/rp_decoupler_pkg.sv | 16 +
 rtl/rp_decoupler_axis_gate.sv | 48 ++++
 rtl/rp_decoupler.sv | 154 +++++++++++++++
 tb/tb_rp_decoupler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_decoupler_pkg.sv
// Shared state encoding and default parameter values for the
// partial-reconfiguration decoupler.
package rp_decoupler_pkg;

    typedef logic [1:0] rp_state_t;

    localparam rp_state_t StActive    = 2'd0;
    localparam rp_state_t StDraining  = 2'd1;
    localparam rp_state_t StDecoupled = 2'd2;

    localparam int unsigned DefNumChannels   = 4;
    localparam int unsigned DefDataWidth     = 8;
    localparam int unsigned DefMaxOutstanding = 16;
    localparam int unsigned DefDrainTimeout  = 65535;

endpackage

// File: rtl/rp_decoupler_axis_gate.sv
// One AXI-Stream channel: tracks whether a frame is open and gates the
// valid/ready handshake according to the decoupler state.
module rp_decoupler_axis_gate
    import rp_decoupler_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  rp_state_t state,
    input  logic      clear,
    input  logic      s_tvalid,
    input  logic      s_tlast,
    input  logic      m_tready,
    output logic      m_tvalid,
    output logic      s_tready,
    output logic      at_boundary
);

    logic in_frame_q;
    logic in_frame_d;
    logic pass;
    logic xfer;

    // While draining, only a channel with an open frame may finish it.
    assign pass = (state == StActive) || ((state == StDraining) && in_frame_q);

    assign m_tvalid    = s_tvalid & pass;
    assign s_tready    = m_tready & pass;
    assign xfer        = s_tvalid & m_tready & pass;
    assign at_boundary = ~in_frame_q;

    always_comb begin
        in_frame_d = in_frame_q;
        if (clear) begin
            in_frame_d = 1'b0;
        end else if (xfer) begin
            in_frame_d = ~s_tlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_q <= 1'b0;
        end else begin
            in_frame_q <= in_frame_d;
        end
    end

endmodule

// File: rtl/rp_decoupler.sv
// Decouples a reconfigurable partition: drains open stream frames and AXI
// bursts on request, then isolates the partition until the request drops.
module rp_decoupler
    import rp_decoupler_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS    = DefNumChannels,
    parameter int unsigned C_DATA_WIDTH      = DefDataWidth,
    parameter int unsigned C_MAX_OUTSTANDING = DefMaxOutstanding,
    parameter int unsigned C_DRAIN_TIMEOUT   = DefDrainTimeout
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   shutdown_req,
    output logic                                   shutdown_ack,
    output logic                                   active,
    output logic                                   drain_timeout,
    input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_CHANNELS-1:0]              s_axis_tuser,
    input  logic [C_NUM_CHANNELS-1:0]              s_axis_tlast,
    input  logic [C_NUM_CHANNELS-1:0]              s_axis_tvalid,
    output logic [C_NUM_CHANNELS-1:0]              s_axis_tready,
    output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_NUM_CHANNELS-1:0]              m_axis_tuser,
    output logic [C_NUM_CHANNELS-1:0]              m_axis_tlast,
    output logic [C_NUM_CHANNELS-1:0]              m_axis_tvalid,
    input  logic [C_NUM_CHANNELS-1:0]              m_axis_tready,
    input  logic                                   s_axi_arvalid,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_arready,
    output logic                                   s_axi_awready,
    output logic                                   m_axi_arvalid,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_arready,
    input  logic                                   m_axi_awready,
    input  logic                                   axi_rvalid,
    input  logic                                   axi_rready,
    input  logic                                   axi_rlast,
    input  logic                                   axi_bvalid,
    input  logic                                   axi_bready
);

    localparam int unsigned CntW    = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned ToW     = (C_DRAIN_TIMEOUT > 0) ? $clog2(C_DRAIN_TIMEOUT + 1) : 1;
    localparam int unsigned ToLimit = (C_DRAIN_TIMEOUT > 0) ? C_DRAIN_TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntMax = CntW'(C_MAX_OUTSTANDING);
    localparam logic [ToW-1:0]  ToLast = ToW'(ToLimit);

    rp_state_t           state_q, state_d;
    logic                active_q, ack_q, timeout_q, timeout_d;
    logic [CntW-1:0]     rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic [C_NUM_CHANNELS-1:0] boundary;
    logic                ar_open, aw_open, rd_inc, rd_dec, wr_inc, wr_dec;
    logic                drain_done, to_hit, start_drain;

    for (genvar ch = 0; ch < C_NUM_CHANNELS; ch++) begin : g_ch
        rp_decoupler_axis_gate u_gate (
            .clk         (clk),
            .rst_n       (rst_n),
            .state       (state_q),
            .clear       (to_hit),
            .s_tvalid    (s_axis_tvalid[ch]),
            .s_tlast     (s_axis_tlast[ch]),
            .m_tready    (m_axis_tready[ch]),
            .m_tvalid    (m_axis_tvalid[ch]),
            .s_tready    (s_axis_tready[ch]),
            .at_boundary (boundary[ch])
        );
    end

    // Payload sidebands are never gated; only the handshake is.
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;

    assign ar_open       = (state_q == StActive) && (rd_count_q < CntMax);
    assign aw_open       = (state_q == StActive) && (wr_count_q < CntMax);
    assign m_axi_arvalid = s_axi_arvalid & ar_open;
    assign s_axi_arready = m_axi_arready & ar_open;
    assign m_axi_awvalid = s_axi_awvalid & aw_open;
    assign s_axi_awready = m_axi_awready & aw_open;

    assign rd_inc = s_axi_arvalid & m_axi_arready & ar_open;
    assign rd_dec = axi_rvalid & axi_rready & axi_rlast & (rd_count_q != '0);
    assign wr_inc = s_axi_awvalid & m_axi_awready & aw_open;
    assign wr_dec = axi_bvalid & axi_bready & (wr_count_q != '0);

    assign start_drain = (state_q == StActive) && shutdown_req;
    assign drain_done  = (&boundary) && (rd_count_q == '0) && (wr_count_q == '0);
    assign to_hit      = (C_DRAIN_TIMEOUT != 0) && (state_q == StDraining) &&
                         (to_cnt_q == ToLast);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StActive:    if (shutdown_req) state_d = StDraining;
            StDraining:  if (drain_done || to_hit) state_d = StDecoupled;
            StDecoupled: if (!shutdown_req) state_d = StActive;
            default:     state_d = StActive;
        endcase
    end

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (to_hit) begin
            rd_count_d = '0;
            wr_count_d = '0;
        end else begin
            if (rd_inc && !rd_dec) rd_count_d = rd_count_q + 1'b1;
            if (rd_dec && !rd_inc) rd_count_d = rd_count_q - 1'b1;
            if (wr_inc && !wr_dec) wr_count_d = wr_count_q + 1'b1;
            if (wr_dec && !wr_inc) wr_count_d = wr_count_q - 1'b1;
        end
    end

    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (start_drain) begin
            to_cnt_d  = '0;
            timeout_d = 1'b0;
        end else if (to_hit) begin
            timeout_d = 1'b1;
        end else if (state_q == StDraining) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StActive;
            active_q   <= 1'b1;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= (state_d == StActive);
            ack_q      <= (state_d == StDecoupled);
            timeout_q  <= timeout_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign active        = active_q;
    assign shutdown_ack  = ack_q;
    assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_rp_decoupler.sv
// Directed bench for rp_decoupler: pass-through vector table plus sequences
// for draining, outstanding-burst limits, timeout and mid-drain reset.
module tb_rp_decoupler;

    localparam int NCh = 4;
    localparam int Dw  = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                shutdown_req, shutdown_ack, active, drain_timeout;
    logic [NCh*Dw-1:0]   s_axis_tdata, m_axis_tdata;
    logic [NCh-1:0]      s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [NCh-1:0]      m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic                s_axi_arvalid, s_axi_awvalid, s_axi_arready, s_axi_awready;
    logic                m_axi_arvalid, m_axi_awvalid, m_axi_arready, m_axi_awready;
    logic                axi_rvalid, axi_rready, axi_rlast, axi_bvalid, axi_bready;

    int tests = 0;
    int fails = 0;

    rp_decoupler #(
        .C_NUM_CHANNELS    (NCh),
        .C_DATA_WIDTH      (Dw),
        .C_MAX_OUTSTANDING (2),
        .C_DRAIN_TIMEOUT   (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shutdown_req  (shutdown_req),
        .shutdown_ack  (shutdown_ack),
        .active        (active),
        .drain_timeout (drain_timeout),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_awready (s_axi_awready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_awready (m_axi_awready),
        .axi_rvalid    (axi_rvalid),
        .axi_rready    (axi_rready),
        .axi_rlast     (axi_rlast),
        .axi_bvalid    (axi_bvalid),
        .axi_bready    (axi_bready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  tvalid;
        logic [3:0]  tlast;
        logic [3:0]  tready;
        logic [3:0]  tuser;
        logic [31:0] tdata;
        logic [3:0]  axi_in;   // {s_arvalid, m_arready, s_awvalid, m_awready}
        logic [3:0]  exp_tvalid;
        logic [3:0]  exp_tready;
        logic [3:0]  exp_axi;  // {m_arvalid, s_arready, m_awvalid, s_awready}
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        m_axis_tready = 4'hF;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_awready = 1'b0;
        axi_rvalid    = 1'b0;
        axi_rready    = 1'b0;
        axi_rlast     = 1'b0;
        axi_bvalid    = 1'b0;
        axi_bready    = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{tvalid: 4'b0000, tlast: 4'b0000, tready: 4'b0000, tuser: 4'b0000,
                    tdata: 32'h0000_0000, axi_in: 4'b0000,
                    exp_tvalid: 4'b0000, exp_tready: 4'b0000, exp_axi: 4'b0000};
        vecs[1] = '{tvalid: 4'b1111, tlast: 4'b1010, tready: 4'b1111, tuser: 4'b0011,
                    tdata: 32'hA5A5_5A5A, axi_in: 4'b1001,
                    exp_tvalid: 4'b1111, exp_tready: 4'b1111, exp_axi: 4'b1001};
        vecs[2] = '{tvalid: 4'b0101, tlast: 4'b0001, tready: 4'b1100, tuser: 4'b1000,
                    tdata: 32'h1234_5678, axi_in: 4'b0110,
                    exp_tvalid: 4'b0101, exp_tready: 4'b1100, exp_axi: 4'b0110};
        vecs[3] = '{tvalid: 4'b1000, tlast: 4'b1000, tready: 4'b0111, tuser: 4'b0100,
                    tdata: 32'hDEAD_BEEF, axi_in: 4'b0000,
                    exp_tvalid: 4'b1000, exp_tready: 4'b0111, exp_axi: 4'b0000};
        vecs[4] = '{tvalid: 4'b0010, tlast: 4'b0000, tready: 4'b0010, tuser: 4'b1111,
                    tdata: 32'h0000_FF00, axi_in: 4'b1010,
                    exp_tvalid: 4'b0010, exp_tready: 4'b0010, exp_axi: 4'b1010};

        rst_n = 1'b0;
        shutdown_req = 1'b0;
        idle();
        #12;
        chk("reset_active", active, 1);
        chk("reset_ack", shutdown_ack, 0);
        chk("reset_timeout", drain_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ACTIVE pass-through table
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = vecs[i].tvalid;
            s_axis_tlast  = vecs[i].tlast;
            m_axis_tready = vecs[i].tready;
            s_axis_tuser  = vecs[i].tuser;
            s_axis_tdata  = vecs[i].tdata;
            {s_axi_arvalid, m_axi_arready, s_axi_awvalid, m_axi_awready} = vecs[i].axi_in;
            #1;
            chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_tvalid);
            chk($sformatf("vec%0d_tready", i), s_axis_tready, vecs[i].exp_tready);
            chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].tdata);
            chk($sformatf("vec%0d_tuser", i), m_axis_tuser, vecs[i].tuser);
            chk($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].tlast);
            chk($sformatf("vec%0d_axi", i),
                {m_axi_arvalid, s_axi_arready, m_axi_awvalid, s_axi_awready}, vecs[i].exp_axi);
            step();
        end
        idle();
        reset_pulse();

        // Idle shutdown: active drops after one cycle, ack after two
        shutdown_req = 1'b1;
        step();
        chk("idle_active_drop", active, 0);
        chk("idle_ack_early", shutdown_ack, 0);
        s_axis_tvalid = 4'hF;
        s_axis_tdata  = 32'h0102_0304;
        #1;
        chk("idle_drain_tready", s_axis_tready, 4'h0);
        step();
        chk("idle_ack", shutdown_ack, 1);
        chk("decoupled_tvalid", m_axis_tvalid, 4'h0);
        chk("decoupled_tready", s_axis_tready, 4'h0);
        chk("decoupled_tdata", m_axis_tdata, 32'h0102_0304);
        idle();
        shutdown_req = 1'b0;
        step();
        chk("idle_reactivate", active, 1);
        chk("idle_ack_clear", shutdown_ack, 0);

        // Channel 2 mid-frame: 3 beats, then shutdown, remaining 7 beats pass
        s_axis_tvalid = 4'b0100;
        repeat (3) step();
        s_axis_tvalid = 4'b0101;
        s_axis_tlast  = 4'b0001;
        shutdown_req  = 1'b1;
        #1;
        chk("frame_beat4_active", m_axis_tvalid, 4'b0101);
        step();
        for (int b = 5; b <= 10; b++) begin
            s_axis_tlast = {1'b0, (b == 10), 1'b0, 1'b1};
            #1;
            chk($sformatf("frame_beat%0d_tvalid", b), m_axis_tvalid, 4'b0100);
            chk($sformatf("frame_beat%0d_tready", b), s_axis_tready, 4'b0100);
            chk($sformatf("frame_beat%0d_ack", b), shutdown_ack, 0);
            step();
        end
        chk("frame_ack_at_tlast", shutdown_ack, 0);
        chk("frame_closed_blocked", m_axis_tvalid, 4'b0000);
        idle();
        step();
        chk("frame_ack", shutdown_ack, 1);
        shutdown_req = 1'b0;
        step();
        chk("frame_reactivate", active, 1);

        // Outstanding read limit of 2
        m_axi_arready = 1'b1;
        s_axi_arvalid = 1'b1;
        #1;
        chk("ar1_ready", s_axi_arready, 1);
        step();
        chk("ar2_ready", s_axi_arready, 1);
        step();
        chk("ar3_stall_valid", m_axi_arvalid, 0);
        chk("ar3_stall_ready", s_axi_arready, 0);
        step();
        chk("ar3_still_stalled", s_axi_arready, 0);
        {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
        step();
        chk("ar_after_rlast", s_axi_arready, 1);
        step();  // AR and rlast together at count 1
        {axi_rvalid, axi_rready, axi_rlast} = 3'b000;
        #1;
        chk("ar_same_cycle_keeps", s_axi_arready, 1);
        step();
        chk("ar_full_again", s_axi_arready, 0);

        // Drain with two reads outstanding; request drop is ignored mid-drain
        shutdown_req = 1'b1;
        step();
        chk("drain_ar_blocked", m_axi_arvalid, 0);
        shutdown_req = 1'b0;
        repeat (3) step();
        chk("drain_wait_ack", shutdown_ack, 0);
        chk("drain_wait_active", active, 0);
        {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
        step();
        {axi_rvalid, axi_rready, axi_rlast} = 3'b000;
        step();
        chk("drain_one_left", shutdown_ack, 0);
        {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
        step();
        {axi_rvalid, axi_rready, axi_rlast} = 3'b000;
        s_axi_arvalid = 1'b0;
        chk("drain_ack_early", shutdown_ack, 0);
        step();
        chk("drain_ack", shutdown_ack, 1);
        step();
        chk("drain_exit_active", active, 1);
        chk("drain_exit_ack", shutdown_ack, 0);

        // rlast at count 0 must not wrap the counter
        {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
        step();
        {axi_rvalid, axi_rready, axi_rlast} = 3'b000;
        s_axi_arvalid = 1'b1;
        step();
        chk("no_wrap_count1", s_axi_arready, 1);
        step();
        chk("no_wrap_count2", s_axi_arready, 0);
        s_axi_arvalid = 1'b0;
        {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
        repeat (2) step();
        idle();

        // Write side: drain waits for the B response
        m_axi_awready = 1'b1;
        s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        shutdown_req  = 1'b1;
        repeat (3) step();
        chk("wr_drain_wait", shutdown_ack, 0);
        {axi_bvalid, axi_bready} = 2'b11;
        step();
        {axi_bvalid, axi_bready} = 2'b00;
        chk("wr_ack_early", shutdown_ack, 0);
        step();
        chk("wr_ack", shutdown_ack, 1);
        shutdown_req = 1'b0;
        step();
        idle();

        // Timeout: partition stalls mid-frame with a read outstanding
        s_axis_tvalid = 4'b0010;
        m_axi_arready = 1'b1;
        s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        m_axis_tready = 4'h0;
        shutdown_req  = 1'b1;
        step();
        chk("to_active_drop", active, 0);
        chk("to_inframe_valid", m_axis_tvalid, 4'b0010);
        chk("to_inframe_ready", s_axis_tready, 4'b0000);
        repeat (99) step();
        chk("to_ack_at_99", shutdown_ack, 0);
        chk("to_flag_at_99", drain_timeout, 0);
        step();
        chk("to_ack", shutdown_ack, 1);
        chk("to_flag", drain_timeout, 1);
        idle();
        shutdown_req = 1'b0;
        step();
        chk("to_flag_sticky", drain_timeout, 1);
        shutdown_req = 1'b1;
        step();
        chk("to_flag_cleared", drain_timeout, 0);
        step();
        chk("to_state_cleared", shutdown_ack, 1);
        shutdown_req = 1'b0;
        step();

        // Reset while draining mid-frame
        s_axis_tvalid = 4'b1000;
        step();
        s_axis_tvalid = 4'b1001;
        s_axis_tlast  = 4'b0001;
        shutdown_req  = 1'b1;
        step();
        chk("rst_pre_gate", m_axis_tvalid, 4'b1000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_active", active, 1);
        chk("rst_async_ack", shutdown_ack, 0);
        shutdown_req = 1'b0;
        idle();
        #1;
        rst_n = 1'b1;
        step();
        s_axis_tvalid = 4'hF;
        #1;
        chk("rst_passthru_valid", m_axis_tvalid, 4'hF);
        chk("rst_passthru_ready", s_axis_tready, 4'hF);
        idle();
        shutdown_req = 1'b1;
        step();
        step();
        chk("rst_inframe_cleared", shutdown_ack, 1);
        shutdown_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
